rif_regbank: RTL and testbench

Register bank that sits directly downstream of the AHB-Lite adapter and terminates its RIF (register interface) port. It decodes `rif_addr`, returns read data combinationally in the same cycle as the request, and flags unmapped or illegal accesses through `rif_addr_valid`. It holds control, scratch, sticky W1C status and interrupt-mask registers, an optional reload down-counter timer, and a registered interrupt output.

---
 rtl/rif_regbank.sv | 193 +++++++++++++++++++
 tb/tb_rif_regbank.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rif_regbank.sv
// ---------------------------------------------------------------------------
// rif_regbank
//
// Register bank terminating the RIF port of the AHB-Lite adapter. Decodes the
// word address, returns read data combinationally, and flags unmapped or
// read-only-write accesses through rif_addr_valid.
//
// Register map (byte offsets):
//   0x00 ID          RO   ID_VALUE
//   0x04 CTRL        RW   bit0 TEN (timer enable), bit1 GIE, rest storage
//   0x08 STATUS      W1C  [EVT_W-1:0] events, bit31 timer expiry
//   0x0C IRQ_MASK    RW   only bits implemented in STATUS are stored
//   0x10 SCRATCH     RW
//   0x14 TIMER_LOAD  RW   (timer build only)
//   0x18 TIMER_VAL   RO   (timer build only)
//
// Optional feature macro: RIF_REGBANK_TIMER_EN
//   defined   : reload down-counter timer, TIMER_LOAD/TIMER_VAL, STATUS[31]
//   undefined : 0x14/0x18 unmapped, STATUS[31] = 0, CTRL.TEN plain storage
//
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   rif_addr        byte address, bits [1:0] ignored
//   rif_addr_valid  combinational access legality
//   rif_wr_req      write strobe (data phase)
//   rif_rd_req      read strobe (address phase)
//   rif_wstrb       byte-lane enables, lane 0 = bits [7:0]
//   rif_wdata       write data
//   rif_rdata       combinational read data
//   evt_i           event pulses, each sets its STATUS bit
//   irq_o           registered interrupt
//   ctrl_o          current CTRL value
// ---------------------------------------------------------------------------
module rif_regbank #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          EVT_W      = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5249_4601
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] rif_addr,
  output logic                  rif_addr_valid,
  input  logic                  rif_wr_req,
  input  logic                  rif_rd_req,
  input  logic [3:0]            rif_wstrb,
  input  logic [DATA_WIDTH-1:0] rif_wdata,
  output logic [DATA_WIDTH-1:0] rif_rdata,
  input  logic [EVT_W-1:0]      evt_i,
  output logic                  irq_o,
  output logic [31:0]           ctrl_o
);

  // Elaboration-time parameter checks.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $fatal(1, "rif_regbank: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 5) begin : g_bad_addr_width
    $fatal(1, "rif_regbank: ADDR_WIDTH must be >= 5");
  end
  if (EVT_W < 1 || EVT_W > 31) begin : g_bad_evt_w
    $fatal(1, "rif_regbank: EVT_W must be in 1..31");
  end

  localparam int WAW = ADDR_WIDTH - 2;

  localparam logic [WAW-1:0] W_ID     = WAW'(0);
  localparam logic [WAW-1:0] W_CTRL   = WAW'(1);
  localparam logic [WAW-1:0] W_STATUS = WAW'(2);
  localparam logic [WAW-1:0] W_MASK   = WAW'(3);
  localparam logic [WAW-1:0] W_SCR    = WAW'(4);

  // Bits of STATUS (and therefore IRQ_MASK) that physically exist.
  localparam logic [31:0] EVT_BITS = (32'h1 << EVT_W) - 32'h1;
`ifdef RIF_REGBANK_TIMER_EN
  localparam logic [WAW-1:0] W_TLOAD = WAW'(5);
  localparam logic [WAW-1:0] W_TVAL  = WAW'(6);
  localparam logic [31:0]    IMPL_BITS = EVT_BITS | 32'h8000_0000;
`else
  localparam logic [31:0]    IMPL_BITS = EVT_BITS;
`endif

  logic [WAW-1:0] word_addr;
  logic           unused_addr_bits;
  logic           sel_id, sel_ctrl, sel_status, sel_mask, sel_scr;
  logic           sel_tload, sel_tval;
  logic           mapped, ro_target, wr_en;
  logic [31:0]    lane_mask;
  logic [31:0]    ctrl_q, status_q, mask_q, scr_q;
  logic [31:0]    tload_q, tval_q;
  logic           tmr_expire;
  logic [31:0]    set_bits, clr_bits, status_d;
  logic [31:0]    rd_val;
  logic           irq_q;

  assign word_addr        = rif_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^rif_addr[1:0];

  assign sel_id     = (word_addr == W_ID);
  assign sel_ctrl   = (word_addr == W_CTRL);
  assign sel_status = (word_addr == W_STATUS);
  assign sel_mask   = (word_addr == W_MASK);
  assign sel_scr    = (word_addr == W_SCR);
`ifdef RIF_REGBANK_TIMER_EN
  assign sel_tload  = (word_addr == W_TLOAD);
  assign sel_tval   = (word_addr == W_TVAL);
`else
  assign sel_tload  = 1'b0;
  assign sel_tval   = 1'b0;
`endif

  assign mapped    = sel_id | sel_ctrl | sel_status | sel_mask | sel_scr |
                     sel_tload | sel_tval;
  assign ro_target = sel_id | sel_tval;

  // A write aimed at a read-only register is reported illegal and dropped.
  assign rif_addr_valid = mapped & ~(rif_wr_req & ro_target);
  assign wr_en          = rif_wr_req & rif_addr_valid;

  assign lane_mask = {{8{rif_wstrb[3]}}, {8{rif_wstrb[2]}},
                      {8{rif_wstrb[1]}}, {8{rif_wstrb[0]}}};

  // Plain RW registers with byte-lane merge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= 32'h0;
      mask_q <= 32'h0;
      scr_q  <= 32'h0;
    end else if (wr_en) begin
      if (sel_ctrl) ctrl_q <= (rif_wdata & lane_mask) | (ctrl_q & ~lane_mask);
      if (sel_mask) mask_q <= ((rif_wdata & lane_mask) | (mask_q & ~lane_mask)) & IMPL_BITS;
      if (sel_scr)  scr_q  <= (rif_wdata & lane_mask) | (scr_q & ~lane_mask);
    end
  end

`ifdef RIF_REGBANK_TIMER_EN
  logic [31:0] tload_new;

  assign tload_new  = (rif_wdata & lane_mask) | (tload_q & ~lane_mask);
  assign tmr_expire = ctrl_q[0] & (tval_q == 32'h0);

  // A TIMER_LOAD write reloads the counter directly, overriding the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tload_q <= 32'h0;
      tval_q  <= 32'h0;
    end else if (wr_en && sel_tload) begin
      tload_q <= tload_new;
      tval_q  <= tload_new;
    end else if (ctrl_q[0]) begin
      tval_q  <= tmr_expire ? tload_q : (tval_q - 32'h1);
    end
  end
`else
  assign tload_q    = 32'h0;
  assign tval_q     = 32'h0;
  assign tmr_expire = 1'b0;
`endif

  // Sticky status: a set in the same cycle as a W1C clear wins.
  always_comb begin
    set_bits = 32'(evt_i);
    set_bits[31] = tmr_expire;
    clr_bits = (wr_en && sel_status) ? (rif_wdata & lane_mask) : 32'h0;
    status_d = ((status_q & ~clr_bits) | set_bits) & IMPL_BITS;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      status_q <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= ctrl_q[1] & (|(status_q & mask_q));
    end
  end

  always_comb begin
    rd_val = 32'h0;
    if (sel_id)     rd_val = ID_VALUE;
    if (sel_ctrl)   rd_val = ctrl_q;
    if (sel_status) rd_val = status_q;
    if (sel_mask)   rd_val = mask_q;
    if (sel_scr)    rd_val = scr_q;
    if (sel_tload)  rd_val = tload_q;
    if (sel_tval)   rd_val = tval_q;
  end

  assign rif_rdata = rif_rd_req ? rd_val : 32'h0;
  assign irq_o     = irq_q;
  assign ctrl_o    = ctrl_q;

endmodule

// File: tb/tb_rif_regbank.sv
// ---------------------------------------------------------------------------
// tb_rif_regbank
//
// Self-checking bench for rif_regbank. Read results go through a scoreboard:
// the expected rdata/addr_valid pair is queued when a read is driven and
// popped against the observed pair at the end of each scenario task.
// Timer scenarios are compiled only when RIF_REGBANK_TIMER_EN is defined.
// ---------------------------------------------------------------------------
module tb_rif_regbank;

  logic        HCLK;
  logic        HRESETn;
  logic [11:0] rif_addr;
  logic        rif_addr_valid;
  logic        rif_wr_req;
  logic        rif_rd_req;
  logic [3:0]  rif_wstrb;
  logic [31:0] rif_wdata;
  logic [31:0] rif_rdata;
  logic [7:0]  evt_i;
  logic        irq_o;
  logic [31:0] ctrl_o;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        valid;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] obs_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        wr_valid_seen;

  rif_regbank #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .EVT_W(8),
    .ID_VALUE(32'h5249_4601)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .rif_addr(rif_addr),
    .rif_addr_valid(rif_addr_valid),
    .rif_wr_req(rif_wr_req),
    .rif_rd_req(rif_rd_req),
    .rif_wstrb(rif_wstrb),
    .rif_wdata(rif_wdata),
    .rif_rdata(rif_rdata),
    .evt_i(evt_i),
    .irq_o(irq_o),
    .ctrl_o(ctrl_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Queue the expected response of the next read.
  task automatic expect_rd(input string name, input logic [31:0] data, input logic valid);
    exp_t e;
    e.name = name;
    e.data = data;
    e.valid = valid;
    exp_q.push_back(e);
  endtask

  // Drive a read mid-cycle and capture the combinational response.
  task automatic drive_rd(input logic [11:0] a, input logic rd);
    rif_addr   = a;
    rif_rd_req = rd;
    rif_wr_req = 1'b0;
    #1;
    obs_q.push_back({rif_addr_valid, rif_rdata});
    rif_rd_req = 1'b0;
  endtask

  // One-cycle write; returns at the falling edge after the write edge.
  task automatic drive_wr(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [7:0] ev);
    @(negedge HCLK);
    rif_addr   = a;
    rif_wdata  = d;
    rif_wstrb  = s;
    rif_wr_req = 1'b1;
    rif_rd_req = 1'b0;
    evt_i      = ev;
    #1 wr_valid_seen = rif_addr_valid;
    @(negedge HCLK);
    rif_wr_req = 1'b0;
    rif_wstrb  = 4'h0;
    rif_wdata  = 32'h0;
    evt_i      = 8'h0;
  endtask

  task automatic pulse_evt(input logic [7:0] ev);
    @(negedge HCLK);
    evt_i = ev;
    @(negedge HCLK);
    evt_i = 8'h0;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [32:0] o;
    HRESETn    = 1'b0;
    rif_addr   = 12'h0;
    rif_wr_req = 1'b0;
    rif_rd_req = 1'b0;
    rif_wstrb  = 4'h0;
    rif_wdata  = 32'h0;
    evt_i      = 8'h0;
    #2;
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_irq: got %b need 0", irq_o);
    end
    total++;
    if (ctrl_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_o: got %h need 0", ctrl_o);
    end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    expect_rd("id_read", 32'h5249_4601, 1'b1);      drive_rd(12'h000, 1'b1);
    expect_rd("id_read_lowbits", 32'h5249_4601, 1'b1); drive_rd(12'h003, 1'b1);
    expect_rd("unmapped_1c", 32'h0, 1'b0);          drive_rd(12'h01C, 1'b1);
    expect_rd("unmapped_high", 32'h0, 1'b0);        drive_rd(12'h404, 1'b1);
    expect_rd("ctrl_reset", 32'h0, 1'b1);           drive_rd(12'h004, 1'b1);
    expect_rd("status_reset", 32'h0, 1'b1);         drive_rd(12'h008, 1'b1);
    expect_rd("mask_reset", 32'h0, 1'b1);           drive_rd(12'h00C, 1'b1);
    expect_rd("scratch_reset", 32'h0, 1'b1);        drive_rd(12'h010, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask

  task automatic test_scratch();
    exp_t        e;
    logic [32:0] o;
    drive_wr(12'h010, 32'hA5A5_A5A5, 4'b0101, 8'h0);
    expect_rd("scratch_strb0101", 32'h00A5_00A5, 1'b1); drive_rd(12'h010, 1'b1);
    drive_wr(12'h010, 32'hFFFF_FFFF, 4'b1000, 8'h0);
    expect_rd("scratch_strb1000", 32'hFFA5_00A5, 1'b1); drive_rd(12'h010, 1'b1);
    drive_wr(12'h010, 32'h1234_5678, 4'b0000, 8'h0);
    expect_rd("scratch_nostrb", 32'hFFA5_00A5, 1'b1);   drive_rd(12'h010, 1'b1);
    expect_rd("scratch_no_rdreq", 32'h0, 1'b1);         drive_rd(12'h010, 1'b0);
    drive_wr(12'h004, 32'hDEAD_BEEC, 4'b1111, 8'h0);
    total++;
    if (ctrl_o !== 32'hDEAD_BEEC) begin
      bad++;
      $display("[TB] FAIL ctrl_o_write: got %h need deadbeec", ctrl_o);
    end
    expect_rd("ctrl_read", 32'hDEAD_BEEC, 1'b1);        drive_rd(12'h004, 1'b1);
    drive_wr(12'h004, 32'h0, 4'b1111, 8'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask

  task automatic test_status_irq();
    exp_t        e;
    logic [32:0] o;
    pulse_evt(8'h08);
    expect_rd("status_evt3", 32'h8, 1'b1); drive_rd(12'h008, 1'b1);
    drive_wr(12'h00C, 32'h8, 4'b1111, 8'h0);
    drive_wr(12'h004, 32'h2, 4'b1111, 8'h0);
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_latency: got %b need 0", irq_o);
    end
    @(negedge HCLK);
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL irq_rise: got %b need 1", irq_o);
    end
    drive_wr(12'h008, 32'h1, 4'b1111, 8'h0);
    expect_rd("w1c_other_bit", 32'h8, 1'b1); drive_rd(12'h008, 1'b1);
    drive_wr(12'h008, 32'h8, 4'b1110, 8'h0);
    expect_rd("w1c_lane_off", 32'h8, 1'b1); drive_rd(12'h008, 1'b1);
    drive_wr(12'h008, 32'h8, 4'b1111, 8'h0);
    expect_rd("w1c_clear", 32'h0, 1'b1); drive_rd(12'h008, 1'b1);
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL irq_hold_after_clear: got %b need 1", irq_o);
    end
    @(negedge HCLK);
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_fall: got %b need 0", irq_o);
    end
    pulse_evt(8'h08);
    drive_wr(12'h008, 32'h8, 4'b1111, 8'h08);
    expect_rd("set_beats_clear", 32'h8, 1'b1); drive_rd(12'h008, 1'b1);
    drive_wr(12'h008, 32'h8, 4'b1111, 8'h0);
    drive_wr(12'h008, 32'hFFFF_FFFF, 4'b1111, 8'h0);
    total++;
    if (wr_valid_seen !== 1'b1) begin
      bad++;
      $display("[TB] FAIL status_wr_valid: got %b need 1", wr_valid_seen);
    end
    expect_rd("status_all_ones_clear", 32'h0, 1'b1); drive_rd(12'h008, 1'b1);
    @(negedge HCLK);
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_idle: got %b need 0", irq_o);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask

  task automatic test_ro_write();
    exp_t        e;
    logic [32:0] o;
    drive_wr(12'h000, 32'h1234_5678, 4'b1111, 8'h0);
    total++;
    if (wr_valid_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL id_wr_valid: got %b need 0", wr_valid_seen);
    end
    expect_rd("id_after_write", 32'h5249_4601, 1'b1); drive_rd(12'h000, 1'b1);
`ifdef RIF_REGBANK_TIMER_EN
    drive_wr(12'h014, 32'h5, 4'b1111, 8'h0);
    drive_wr(12'h018, 32'h0000_FFFF, 4'b1111, 8'h0);
    total++;
    if (wr_valid_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tval_wr_valid: got %b need 0", wr_valid_seen);
    end
    expect_rd("tval_unchanged", 32'h5, 1'b1); drive_rd(12'h018, 1'b1);
`else
    drive_wr(12'h018, 32'h0000_FFFF, 4'b1111, 8'h0);
    total++;
    if (wr_valid_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tval_wr_valid: got %b need 0", wr_valid_seen);
    end
    expect_rd("tval_unmapped", 32'h0, 1'b0);   drive_rd(12'h018, 1'b1);
    expect_rd("tload_unmapped", 32'h0, 1'b0);  drive_rd(12'h014, 1'b1);
    drive_wr(12'h014, 32'h0000_0003, 4'b1111, 8'h0);
    total++;
    if (wr_valid_seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tload_wr_valid: got %b need 0", wr_valid_seen);
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask

`ifdef RIF_REGBANK_TIMER_EN
  task automatic test_timer();
    exp_t        e;
    logic [32:0] o;
    logic [31:0] val_seq [9];
    val_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    drive_wr(12'h014, 32'h3, 4'b1111, 8'h0);
    expect_rd("tval_after_load", 32'h3, 1'b1); drive_rd(12'h018, 1'b1);
    drive_wr(12'h004, 32'h3, 4'b1111, 8'h0);
    for (int i = 0; i < 9; i++) begin
      expect_rd($sformatf("tval_seq%0d", i), val_seq[i], 1'b1);
      drive_rd(12'h018, 1'b1);
      expect_rd($sformatf("tstat_seq%0d", i), (i >= 4) ? 32'h8000_0000 : 32'h0, 1'b1);
      drive_rd(12'h008, 1'b1);
      @(negedge HCLK);
    end
    drive_wr(12'h014, 32'h0000_0010, 4'b0001, 8'h0);
    expect_rd("tval_load_override", 32'h10, 1'b1); drive_rd(12'h018, 1'b1);
    expect_rd("tload_readback", 32'h10, 1'b1);     drive_rd(12'h014, 1'b1);
    @(negedge HCLK);
    expect_rd("tval_after_override", 32'hF, 1'b1); drive_rd(12'h018, 1'b1);
    drive_wr(12'h00C, 32'h8000_0008, 4'b1111, 8'h0);
    @(negedge HCLK);
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timer_irq: got %b need 1", irq_o);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_irq: got %b need 0", irq_o);
    end
    expect_rd("async_reset_tval", 32'h0, 1'b1);   drive_rd(12'h018, 1'b1);
    expect_rd("async_reset_status", 32'h0, 1'b1); drive_rd(12'h008, 1'b1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive_wr(12'h004, 32'h1, 4'b1111, 8'h0);
    expect_rd("load0_first", 32'h0, 1'b1); drive_rd(12'h008, 1'b1);
    @(negedge HCLK);
    expect_rd("load0_expire", 32'h8000_0000, 1'b1); drive_rd(12'h008, 1'b1);
    expect_rd("load0_tval", 32'h0, 1'b1);           drive_rd(12'h018, 1'b1);
    drive_wr(12'h004, 32'h0, 4'b1111, 8'h0);
    drive_wr(12'h008, 32'h8000_0000, 4'b1000, 8'h0);
    expect_rd("timer_status_cleared", 32'h0, 1'b1); drive_rd(12'h008, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask
`endif

  task automatic test_mask();
    exp_t        e;
    logic [32:0] o;
    drive_wr(12'h00C, 32'hFFFF_FFFF, 4'b1111, 8'h0);
`ifdef RIF_REGBANK_TIMER_EN
    expect_rd("mask_impl_bits", 32'h8000_00FF, 1'b1); drive_rd(12'h00C, 1'b1);
`else
    expect_rd("mask_impl_bits", 32'h0000_00FF, 1'b1); drive_rd(12'h00C, 1'b1);
`endif
    drive_wr(12'h00C, 32'h0000_0000, 4'b0010, 8'h0);
`ifdef RIF_REGBANK_TIMER_EN
    expect_rd("mask_lane1_only", 32'h8000_00FF, 1'b1); drive_rd(12'h00C, 1'b1);
`else
    expect_rd("mask_lane1_only", 32'h0000_00FF, 1'b1); drive_rd(12'h00C, 1'b1);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 33'h0;
      total += 2;
      if (o[31:0] !== e.data) begin
        bad++;
        $display("[TB] FAIL %s rdata: got %h need %h", e.name, o[31:0], e.data);
      end
      if (o[32] !== e.valid) begin
        bad++;
        $display("[TB] FAIL %s addr_valid: got %b need %b", e.name, o[32], e.valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_status_irq();
    test_ro_write();
`ifdef RIF_REGBANK_TIMER_EN
    test_timer();
`endif
    test_mask();
    if (obs_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries need 0", obs_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
